// File: rtl/wb_mux_pipe_if.sv
// Bus bundle for the writeback-select stage: decode/execute/memory results
// in, registered writeback request out.
interface wb_mux_pipe_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            in_valid;
  logic            reg_we;
  logic [RA_W-1:0] rd_addr;
  logic [1:0]      rd_sel;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] rd_mem;
  logic [2:0]      mem_fmt;
  logic [1:0]      byte_off;
  logic            stall;
  logic            flush;
  logic [XLEN-1:0] wb_data;
  logic [RA_W-1:0] wb_rd;
  logic            wb_we;
  logic            misalign;

  modport master (
    output in_valid, reg_we, rd_addr, rd_sel, imm, pc, alu_out, rd_mem,
           mem_fmt, byte_off, stall, flush,
    input  wb_data, wb_rd, wb_we, misalign
  );

  modport slave (
    input  in_valid, reg_we, rd_addr, rd_sel, imm, pc, alu_out, rd_mem,
           mem_fmt, byte_off, stall, flush,
    output wb_data, wb_rd, wb_we, misalign
  );
endinterface

// File: rtl/wb_mux_pipe.sv
// Registered writeback-select stage for the rysy core. Picks the rd source
// (immediate, delayed PC (+4), ALU, or extended load data), suppresses x0
// and misaligned-load writes, and honours stall/flush.
module wb_mux_pipe #(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int PC_DELAY = 1,
  parameter int PCP4_ADD = 1
) (
  input logic          clk,
  input logic          rst,
  wb_mux_pipe_if.slave bus
);

  localparam logic [1:0] SEL_IMM  = 2'b00;
  localparam logic [1:0] SEL_PCP4 = 2'b01;
  localparam logic [1:0] SEL_ALU  = 2'b10;
  localparam logic [1:0] SEL_MEM  = 2'b11;

  localparam logic [2:0] FMT_LB  = 3'b000;
  localparam logic [2:0] FMT_LH  = 3'b001;
  localparam logic [2:0] FMT_LW  = 3'b010;
  localparam logic [2:0] FMT_LBU = 3'b100;
  localparam logic [2:0] FMT_LHU = 3'b101;

  // Lane extraction plus sign/zero extension; unknown formats behave as LW.
  function automatic logic [XLEN-1:0] f_load_ext(input logic [XLEN-1:0] word,
                                                 input logic [2:0]      fmt,
                                                 input logic [1:0]      off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [XLEN-1:0]    r;
    b = word[8*off +: 8];
    h = word[16*off[1] +: 16];
    case (fmt)
      FMT_LB:  r = {{(XLEN-8){b[7]}}, b};
      FMT_LBU: r = {{(XLEN-8){1'b0}}, b};
      FMT_LH:  r = {{(XLEN-16){h[15]}}, h};
      FMT_LHU: r = {{(XLEN-16){1'b0}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Halfwords need even offsets, words need offset 0; bytes never trap.
  function automatic logic f_misaligned(input logic [2:0] fmt,
                                        input logic [1:0] off);
    logic r;
    case (fmt)
      FMT_LH, FMT_LHU: r = off[0];
      FMT_LW:          r = (off != 2'b00);
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

  logic [XLEN-1:0] w_delayed_pc;
  logic [XLEN-1:0] w_pc_src;
  logic [XLEN-1:0] w_load_val;
  logic [XLEN-1:0] w_sel_val;
  logic            w_bad;
  logic            w_we_nxt;
  logic            w_mis_nxt;

  logic [XLEN-1:0] r_wb_data_p1;
  logic [RA_W-1:0] r_wb_rd_p1;
  logic            r_wb_we_p1;
  logic            r_misalign_p1;

  generate
    if (PC_DELAY == 0) begin : g_pc_direct
      assign w_delayed_pc = bus.pc;
    end else begin : g_pc_delay
      logic [XLEN-1:0] r_pc_dly_p [PC_DELAY];

      // PC shift register, frozen while the stage is stalled.
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < PC_DELAY; i++) r_pc_dly_p[i] <= '0;
        end else if (!bus.stall) begin
          r_pc_dly_p[0] <= bus.pc;
          for (int i = 1; i < PC_DELAY; i++) r_pc_dly_p[i] <= r_pc_dly_p[i-1];
        end
      end

      assign w_delayed_pc = r_pc_dly_p[PC_DELAY-1];
    end
  endgenerate

  assign w_pc_src   = (PCP4_ADD != 0) ? (w_delayed_pc + XLEN'(4)) : w_delayed_pc;
  assign w_load_val = f_load_ext(bus.rd_mem, bus.mem_fmt, bus.byte_off);

  // Source select and write-enable qualification feeding the output register.
  always_comb begin
    w_sel_val = bus.imm;
    case (bus.rd_sel)
      SEL_IMM:  w_sel_val = bus.imm;
      SEL_PCP4: w_sel_val = w_pc_src;
      SEL_ALU:  w_sel_val = bus.alu_out;
      SEL_MEM:  w_sel_val = w_load_val;
      default:  w_sel_val = bus.imm;
    endcase
    w_bad     = (bus.rd_sel == SEL_MEM) && f_misaligned(bus.mem_fmt, bus.byte_off);
    w_we_nxt  = bus.in_valid && bus.reg_we && (bus.rd_addr != '0) && !w_bad && !bus.flush;
    w_mis_nxt = bus.in_valid && w_bad && !bus.flush;
  end

  // ---- stage boundary: selection -> writeback register ----
  // Data/index load only when not stalled; enables also update on flush so a
  // stalled, flushed instruction still loses its write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb_data_p1  <= '0;
      r_wb_rd_p1    <= '0;
      r_wb_we_p1    <= 1'b0;
      r_misalign_p1 <= 1'b0;
    end else begin
      if (!bus.stall) begin
        r_wb_data_p1 <= w_sel_val;
        r_wb_rd_p1   <= bus.rd_addr;
      end
      if (!bus.stall || bus.flush) begin
        r_wb_we_p1    <= w_we_nxt;
        r_misalign_p1 <= w_mis_nxt;
      end
    end
  end

  assign bus.wb_data  = r_wb_data_p1;
  assign bus.wb_rd    = r_wb_rd_p1;
  assign bus.wb_we    = r_wb_we_p1;
  assign bus.misalign = r_misalign_p1;

endmodule

// File: tb/tb_wb_mux_pipe.sv
// Bench for wb_mux_pipe: a PC_DELAY=1 instance (fully checked) and a
// PC_DELAY=0 instance (wb_data checked) driven with identical stimulus.
module tb_wb_mux_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_mux_pipe_if #(.XLEN(32), .RA_W(5)) if1 ();
  wb_mux_pipe_if #(.XLEN(32), .RA_W(5)) if0 ();

  wb_mux_pipe #(.XLEN(32), .RA_W(5), .PC_DELAY(1), .PCP4_ADD(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  wb_mux_pipe #(.XLEN(32), .RA_W(5), .PC_DELAY(0), .PCP4_ADD(1)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic        we;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [2:0]  fmt;
    logic [1:0]  off;
    logic        stall;
    logic        flush;
    logic [31:0] edata;
    logic [4:0]  erd;
    logic        ewe;
    logic        emis;
    logic [31:0] e0data;
  } vec_t;

  localparam logic [31:0] LW = 32'h80F07F81;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(logic r, logic vld, logic we, logic [4:0] rd,
                              logic [1:0] sel, logic [31:0] imm, logic [31:0] pc,
                              logic [31:0] alu, logic [31:0] mem, logic [2:0] fmt,
                              logic [1:0] off, logic stall, logic flush,
                              logic [31:0] edata, logic [4:0] erd, logic ewe,
                              logic emis, logic [31:0] e0data);
    vec_t v;
    v.rst = r; v.vld = vld; v.we = we; v.rd = rd; v.sel = sel; v.imm = imm;
    v.pc = pc; v.alu = alu; v.mem = mem; v.fmt = fmt; v.off = off;
    v.stall = stall; v.flush = flush; v.edata = edata; v.erd = erd;
    v.ewe = ewe; v.emis = emis; v.e0data = e0data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;
    if1.in_valid = v.vld;   if0.in_valid = v.vld;
    if1.reg_we   = v.we;    if0.reg_we   = v.we;
    if1.rd_addr  = v.rd;    if0.rd_addr  = v.rd;
    if1.rd_sel   = v.sel;   if0.rd_sel   = v.sel;
    if1.imm      = v.imm;   if0.imm      = v.imm;
    if1.pc       = v.pc;    if0.pc       = v.pc;
    if1.alu_out  = v.alu;   if0.alu_out  = v.alu;
    if1.rd_mem   = v.mem;   if0.rd_mem   = v.mem;
    if1.mem_fmt  = v.fmt;   if0.mem_fmt  = v.fmt;
    if1.byte_off = v.off;   if0.byte_off = v.off;
    if1.stall    = v.stall; if0.stall    = v.stall;
    if1.flush    = v.flush; if0.flush    = v.flush;
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    drive(v);
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_data"},  if1.wb_data,          e.edata);
    chk({tag, "_rd"},    {27'd0, if1.wb_rd},   {27'd0, e.erd});
    chk({tag, "_we"},    {31'd0, if1.wb_we},   {31'd0, e.ewe});
    chk({tag, "_mis"},   {31'd0, if1.misalign}, {31'd0, e.emis});
    chk({tag, "_data0"}, if0.wb_data,          e.e0data);
  endtask

  initial begin
    vec_t v;

    // Reset held two cycles with random inputs and in_valid=1.
    for (int i = 0; i < 2; i++) begin
      v = mk(1'b0, 1'b1, 1'b1, 5'($urandom), 2'($urandom), $urandom, $urandom,
             $urandom, $urandom, 3'($urandom), 2'($urandom), 1'b0, 1'b0,
             32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
      apply(v, $sformatf("rst%0d", i));
    end

    //            rst vld we rd     sel    imm           pc            alu           mem  fmt     off  st fl  edata         erd    we mis e0data
    vecs.push_back(mk(1, 1, 1, 5'd5,  2'b10, 32'h0,        32'h100,      32'h12345678, 0,   3'b010, 0, 0, 0, 32'h12345678, 5'd5,  1, 0, 32'h12345678));
    vecs.push_back(mk(1, 1, 1, 5'd6,  2'b01, 32'h0,        32'h104,      32'h0,        0,   3'b010, 0, 0, 0, 32'h104,      5'd6,  1, 0, 32'h108));
    vecs.push_back(mk(1, 1, 1, 5'd7,  2'b01, 32'h0,        32'hFFFFFFFC, 32'h0,        0,   3'b010, 0, 0, 0, 32'h108,      5'd7,  1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 5'd7,  2'b01, 32'h0,        32'h0,        32'h0,        0,   3'b010, 0, 0, 0, 32'h0,        5'd7,  1, 0, 32'h4));
    vecs.push_back(mk(1, 1, 1, 5'd8,  2'b11, 32'h0,        32'h0,        32'h0,        LW,  3'b000, 0, 0, 0, 32'hFFFFFF81, 5'd8,  1, 0, 32'hFFFFFF81));
    vecs.push_back(mk(1, 1, 1, 5'd8,  2'b11, 32'h0,        32'h0,        32'h0,        LW,  3'b100, 0, 0, 0, 32'h00000081, 5'd8,  1, 0, 32'h00000081));
    vecs.push_back(mk(1, 1, 1, 5'd8,  2'b11, 32'h0,        32'h0,        32'h0,        LW,  3'b000, 1, 0, 0, 32'h0000007F, 5'd8,  1, 0, 32'h0000007F));
    vecs.push_back(mk(1, 1, 1, 5'd8,  2'b11, 32'h0,        32'h0,        32'h0,        LW,  3'b001, 2, 0, 0, 32'hFFFF80F0, 5'd8,  1, 0, 32'hFFFF80F0));
    vecs.push_back(mk(1, 1, 1, 5'd8,  2'b11, 32'h0,        32'h0,        32'h0,        LW,  3'b101, 2, 0, 0, 32'h000080F0, 5'd8,  1, 0, 32'h000080F0));
    vecs.push_back(mk(1, 1, 1, 5'd8,  2'b11, 32'h0,        32'h0,        32'h0,        LW,  3'b010, 0, 0, 0, 32'h80F07F81, 5'd8,  1, 0, 32'h80F07F81));
    vecs.push_back(mk(1, 1, 1, 5'd8,  2'b11, 32'h0,        32'h0,        32'h0,        LW,  3'b100, 3, 0, 0, 32'h00000080, 5'd8,  1, 0, 32'h00000080));
    vecs.push_back(mk(1, 1, 1, 5'd8,  2'b11, 32'h0,        32'h0,        32'h0,        LW,  3'b011, 2, 0, 0, 32'h80F07F81, 5'd8,  1, 0, 32'h80F07F81));
    vecs.push_back(mk(1, 1, 1, 5'd8,  2'b11, 32'h0,        32'h0,        32'h0,        LW,  3'b001, 1, 0, 0, 32'h00007F81, 5'd8,  0, 1, 32'h00007F81));
    vecs.push_back(mk(1, 1, 1, 5'd8,  2'b11, 32'h0,        32'h0,        32'h0,        LW,  3'b010, 2, 0, 0, 32'h80F07F81, 5'd8,  0, 1, 32'h80F07F81));
    vecs.push_back(mk(1, 1, 1, 5'd8,  2'b11, 32'h0,        32'h0,        32'h0,        LW,  3'b101, 2, 0, 0, 32'h000080F0, 5'd8,  1, 0, 32'h000080F0));
    vecs.push_back(mk(1, 0, 1, 5'd8,  2'b11, 32'h0,        32'h0,        32'h0,        LW,  3'b001, 1, 0, 0, 32'h00007F81, 5'd8,  0, 0, 32'h00007F81));
    vecs.push_back(mk(1, 1, 1, 5'd8,  2'b11, 32'h0,        32'h0,        32'h0,        LW,  3'b001, 1, 0, 1, 32'h00007F81, 5'd8,  0, 0, 32'h00007F81));
    vecs.push_back(mk(1, 1, 1, 5'd11, 2'b10, 32'h0,        32'h0,        32'hCAFEF00D, LW,  3'b001, 1, 0, 0, 32'hCAFEF00D, 5'd11, 1, 0, 32'hCAFEF00D));
    vecs.push_back(mk(1, 1, 1, 5'd12, 2'b00, 32'hDEADBEEF, 32'h0,        32'h0,        0,   3'b010, 0, 0, 0, 32'hDEADBEEF, 5'd12, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 1, 1, 5'd0,  2'b10, 32'h0,        32'h0,        32'hA5A5A5A5, 0,   3'b010, 0, 0, 0, 32'hA5A5A5A5, 5'd0,  0, 0, 32'hA5A5A5A5));
    vecs.push_back(mk(1, 1, 0, 5'd13, 2'b10, 32'h0,        32'h0,        32'h13,       0,   3'b010, 0, 0, 0, 32'h13,       5'd13, 0, 0, 32'h13));
    vecs.push_back(mk(1, 1, 1, 5'd9,  2'b10, 32'h0,        32'h0,        32'h5555AAAA, 0,   3'b010, 0, 0, 0, 32'h5555AAAA, 5'd9,  1, 0, 32'h5555AAAA));
    vecs.push_back(mk(1, 1, 1, 5'd14, 2'b10, 32'h0,        32'h0,        32'h66666666, 0,   3'b010, 0, 0, 1, 32'h66666666, 5'd14, 0, 0, 32'h66666666));
    vecs.push_back(mk(1, 1, 1, 5'd15, 2'b10, 32'h0,        32'h0,        32'h77777777, 0,   3'b010, 0, 0, 0, 32'h77777777, 5'd15, 1, 0, 32'h77777777));
    vecs.push_back(mk(1, 1, 1, 5'd10, 2'b10, 32'h0,        32'h0,        32'h11111111, 0,   3'b010, 0, 1, 1, 32'h77777777, 5'd15, 0, 0, 32'h77777777));
    vecs.push_back(mk(1, 1, 1, 5'd1,  2'b10, 32'h0,        32'h200,      32'h1,        0,   3'b010, 0, 0, 0, 32'h1,        5'd1,  1, 0, 32'h1));
    vecs.push_back(mk(1, 1, 1, 5'd2,  2'b10, 32'h0,        32'h204,      32'h2,        0,   3'b010, 0, 0, 0, 32'h2,        5'd2,  1, 0, 32'h2));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 1, 1, 5'd3, 2'b01, 32'h0,       32'h300,      32'h9,        0,   3'b010, 0, 1, 0, 32'h2,        5'd2,  1, 0, 32'h2));
    vecs.push_back(mk(1, 1, 1, 5'd3,  2'b01, 32'h0,        32'h300,      32'h9,        0,   3'b010, 0, 0, 0, 32'h208,      5'd3,  1, 0, 32'h304));

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Reset wins over stall and clears the PC delay line.
    apply(mk(1'b0, 1'b1, 1'b1, 5'd4, 2'b10, 32'h0, 32'h3FC, 32'hFFFFFFFF, 32'h0,
             3'b010, 2'd0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0), "rst_stall");
    apply(mk(1'b1, 1'b1, 1'b1, 5'd4, 2'b01, 32'h0, 32'h400, 32'h0, 32'h0,
             3'b010, 2'd0, 1'b0, 1'b0, 32'h4, 5'd4, 1'b1, 1'b0, 32'h404), "post_rst_pc");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_mux_pipe.md
Name: wb_mux_pipe

Overview:
Parametrised writeback-select stage for the rysy core. It replaces the combinational rd destination mux with a registered stage. Its result feeds reg_file rd_d and the rd write enable. On top of plain source selection it adds:
- a configurable PC delay line with optional +4 adder
- load-data lane extraction and sign/zero extension
- x0 write suppression
- stall/flush control

Parameters:
XLEN, 32, data width of all sources and wb_data.
RA_W, 5, register address width.
PC_DELAY, 1, PC delay-line depth in cycles (0..4); 0 = PC used directly.
PCP4_ADD, 1, 1: PC source returns delayed_pc+4; 0: returns delayed_pc unmodified.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-low reset.
in_valid  in  1  current instruction valid for writeback.
reg_we  in  1  instruction writes rd.
rd_addr  in  RA_W  destination register index.
rd_sel  in  2  source select: 00 IMM, 01 PCP4, 10 ALU, 11 MEM.
imm  in  XLEN  immediate from decode.
pc  in  XLEN  program counter.
alu_out  in  XLEN  ALU result.
rd_mem  in  XLEN  raw word from data memory (select_rd).
mem_fmt  in  3  load format, funct3 coding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
byte_off  in  2  load address bits [1:0].
stall  in  1  hold stage.
flush  in  1  kill stage.
wb_data  out  XLEN  registered writeback data to reg_file rd_d.
wb_rd  out  RA_W  registered destination index.
wb_we  out  1  registered write enable.
misalign  out  1  registered one-cycle flag: illegal load alignment.

Behaviour:
- Reset (rst=0 at posedge):
  - wb_data=0, wb_rd=0, wb_we=0, misalign=0.
  - All PC delay-line stages cleared to 0.
  - Reset has priority over stall and flush.
- PC delay line:
  - PC_DELAY stages; shifts only on cycles with stall=0.
  - delayed_pc = last stage; PC_DELAY=0 makes delayed_pc=pc combinationally.
  - pc_src = delayed_pc + 4 (mod 2^XLEN, wraps 0xFFFFFFFC -> 0x00000000) if PCP4_ADD=1, else delayed_pc.
- Load extraction (used only when rd_sel=11):
  - Byte lane = rd_mem[8*byte_off +: 8]; half lane = rd_mem[16*byte_off[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW passes rd_mem through unchanged.
  - Illegal alignment: LH/LHU with byte_off[0]=1, or LW with byte_off!=0.
  - Unlisted mem_fmt codes (011, 110, 111): treated as LW, no misalign flag.
- Select: 00 imm, 01 pc_src, 10 alu_out, 11 extracted load value.
- Output register, when stall=0 at posedge:
  - wb_data <= selected value; wb_rd <= rd_addr.
  - wb_we <= in_valid & reg_we & (rd_addr!=0) & ~bad & ~flush, where bad = illegal alignment & rd_sel=11.
  - misalign <= in_valid & bad & ~flush.
  - Latency: exactly 1 cycle from inputs to wb_*.
- stall=1, flush=0: all outputs and the delay line hold their values.
- flush=1 (stall either value): wb_we <= 0 and misalign <= 0.
  - With stall=1, wb_data/wb_rd hold.
  - With stall=0, wb_data/wb_rd load normally.
  - Flush therefore overrides stall for the enables only.
- rd_addr=0: wb_data still loads, wb_we=0.
- in_valid=0: wb_we=0 and misalign=0; data/addr still load (don't-care for consumers).
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random inputs and in_valid=1 -> all outputs 0. First cycle after release with rd_sel=10, alu_out=0x12345678, rd_addr=5, reg_we=1 -> next cycle wb_data=0x12345678, wb_rd=5, wb_we=1.
- PC path (PC_DELAY=1, PCP4_ADD=1), two consecutive unstalled cycles:
  - pc=0x100 -> pc=0x104 with rd_sel=01 on the second -> wb_data=0x104 (0x100+4).
  - pc=0xFFFFFFFC delayed -> wb_data=0x00000000.
  - Repeat with PC_DELAY=0 -> wb_data tracks pc+4 of the same cycle.
- Loads with rd_mem=0x80F07F81:
  - LB off0 -> 0xFFFFFF81.
  - LBU off0 -> 0x00000081.
  - LB off1 -> 0x0000007F.
  - LH off2 -> 0xFFFF80F0.
  - LHU off2 -> 0x000080F0.
  - LW off0 -> 0x80F07F81.
- Misalign: LH with byte_off=1 -> wb_we=0 and misalign=1 for one cycle. LW with byte_off=2 -> same.
- x0 and flush:
  - rd_addr=0, reg_we=1 -> wb_we=0.
  - flush=1 with a valid ALU write -> wb_we=0, wb_data=alu_out.
  - flush=1 with stall=1 -> wb_we=0, wb_data unchanged.
- Stall:
  - Load pc sequence 0x200, 0x204; stall=1 for 3 cycles while pc changes to 0x300 -> outputs and delayed_pc frozen.
  - After release, first PCP4 result = 0x204+4 = 0x208.
